mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Two-port arbiter and access sequencer in front of the byte-addressed data memory: port 0 (instruction fetch), port 1 (load/store unit).
- Memory read is combinational and memory write is synchronous, writing BYTE_SIZE consecutive bytes starting at mem_addr.
- The block serialises requests with round-robin priority and returns registered read data with a one-cycle ack.
- It performs byte and halfword stores as read-modify-write, because the memory always writes full BYTE_SIZE words.

Parameters:
- BYTE_SIZE, 4, bytes per memory word; data width is BYTE_SIZE*8.
- ADDR_WIDTH, 32, address width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req0 / req1  in  1  request from port 0 / port 1.
- we0 / we1  in  1  1 = write, 0 = read.
- size0 / size1  in  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- addr0 / addr1  in  ADDR_WIDTH  byte address.
- wd0 / wd1  in  BYTE_SIZE*8  write data; sub-word data is right-aligned.
- rdata0 / rdata1  out  BYTE_SIZE*8  read data, registered, zero-extended for sub-word sizes.
- ack0 / ack1  out  1  one-cycle completion pulse.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_wd  out  BYTE_SIZE*8  memory write data.
- mem_rd  in  BYTE_SIZE*8  memory read data (combinational from mem_addr).
- busy  out  1  high in every state other than IDLE.

Behaviour:
- Reset values:
  - state=IDLE.
  - ack0=ack1=0, rdata0=rdata1=0.
  - mem_we=0, mem_addr=0, mem_wd=0.
  - last_grant=1, so port 0 wins the first conflict.
- States: IDLE, ACCESS, RMW_WR, RESP.
- Arbitration happens only in IDLE.
  - Single request: that port is granted.
  - Both requesting: the port != last_grant is granted.
  - On grant, latch the port id, we, size, addr and wd; update last_grant.
  - Next state is ACCESS.
- ACCESS:
  - mem_addr = latched addr.
  - Read, or sub-word write: mem_we=0. mem_rd is captured into rd_buf at the clock edge.
  - Word write: mem_we=1, mem_wd = latched wd.
  - Next state is RMW_WR for a sub-word write, otherwise RESP.
- RMW_WR:
  - mem_we=1.
  - mem_wd = rd_buf with the low 8 bits (byte) or low 16 bits (half) replaced by latched wd.
  - Next state is RESP.
- RESP:
  - ack of the granted port = 1 for exactly this cycle; the other ack stays 0.
  - For reads, the granted port's rdata = rd_buf masked to the size, upper bits zero.
  - rdata holds until that port's next read completes.
  - Next state is IDLE.
- Latency, counted from the edge where req is sampled in IDLE:
  - Read or word write: ack in cycle +2.
  - Sub-word write: ack in cycle +3.
  - Throughput: at most one transaction per 3 cycles (4 cycles for RMW).
- Requester rules:
  - Hold req/we/size/addr/wd stable until ack; drop req in the cycle after ack.
  - Dropping req mid-transaction does not abort the transaction; ack still pulses.
- mem_we is never high outside ACCESS or RMW_WR, and is high for exactly one cycle per write.
- Reset mid-operation: the next state is IDLE with no ack.
  - A write in the cycle where reset is sampled still completes in memory.
  - No partial RMW write is issued after reset.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No alignment check is made; unaligned addresses are passed through.

Optional Feature:
- ARB_FIXED_PRI_EN
  - Defined: port 0 always wins a conflict, and last_grant is unused.
  - Undefined: round-robin as above.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum (IDLE, ACCESS, RMW_WR, RESP);
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10.
- Sub-module mem_arb_merge: combinational merge of rd_buf with wd by size, also reused for the read mask.

Test Plan:
- req0 only, read word at addr 0x10, memory holds 0xDEADBEEF -> ack0 in cycle +2, rdata0=0xDEADBEEF, ack1 never high.
- req1 word write 0x12345678 to 0x20 -> mem_we high for one cycle in ACCESS with mem_addr=0x20; a read-back gives 0x12345678.
- req1 byte write 0xAA to 0x20, which holds 0x12345678 -> ACCESS read with no write, RMW_WR writes 0x123456AA, ack1 in cycle +3.
- req0 and req1 asserted together, repeatedly -> grants alternate 0,1,0,1; with ARB_FIXED_PRI_EN, all grants go to port 0 while req0 is held.
- Halfword read at 0x20 holding 0x123456AA -> rdata=0x000056AA.
- reset asserted during RMW_WR -> state IDLE next cycle, no ack, busy=0, mem_we=0 afterwards.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and access-size encodings for the memory arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, RESP} state_t;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
endpackage

// File: rtl/mem_arb_merge.sv
// mem_arb_merge: replaces the low byte/half of base with wd by size; word sizes take wd whole
module mem_arb_merge
  import mem_arb_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] base,
  input  logic [W-1:0] wd,
  input  logic [1:0]   size,
  output logic [W-1:0] out
);
  assign out = size == SZ_BYTE ? {base[W-1:8], wd[7:0]} :
               size == SZ_HALF ? {base[W-1:16], wd[15:0]} : wd;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin memory arbiter with sub-word RMW stores (ARB_FIXED_PRI_EN: port 0 always wins)
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BYTE_SIZE  = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   we0,
  input  logic                   we1,
  input  logic [1:0]             size0,
  input  logic [1:0]             size1,
  input  logic [ADDR_WIDTH-1:0]  addr0,
  input  logic [ADDR_WIDTH-1:0]  addr1,
  input  logic [BYTE_SIZE*8-1:0] wd0,
  input  logic [BYTE_SIZE*8-1:0] wd1,
  output logic [BYTE_SIZE*8-1:0] rdata0,
  output logic [BYTE_SIZE*8-1:0] rdata1,
  output logic                   ack0,
  output logic                   ack1,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [BYTE_SIZE*8-1:0] mem_wd,
  input  logic [BYTE_SIZE*8-1:0] mem_rd,
  output logic                   busy
);
  localparam int DW = BYTE_SIZE * 8;
  state_t                state, nxt;
  logic                  gnt, port_q, we_q, sub_q;
  logic [1:0]            size_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DW-1:0]         wd_q, rd_buf, rmw_wd, rd_mask;
  assign sub_q = we_q && (size_q == SZ_BYTE || size_q == SZ_HALF);
  assign ack0  = state == RESP && !port_q;
  assign ack1  = state == RESP && port_q;
  assign busy  = state != IDLE;
`ifdef ARB_FIXED_PRI_EN
  assign gnt = !req0;
`else
  logic last_grant;
  assign gnt = req0 && req1 ? !last_grant : req1;
  // remember the last winner so a conflict goes to the other port
  always_ff @(posedge clk)
    if (reset) last_grant <= 1'b1;
    else if (state == IDLE && (req0 || req1)) last_grant <= gnt;
`endif
  mem_arb_merge #(.W(DW)) u_rmw (.base(rd_buf), .wd(wd_q), .size(size_q), .out(rmw_wd));
  mem_arb_merge #(.W(DW)) u_rd (.base('0), .wd(mem_rd), .size(size_q), .out(rd_mask));
  // state register
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= nxt;
  // next state and memory-side drive
  always_comb begin
    nxt      = state;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    unique case (state)
      IDLE:    nxt = req0 || req1 ? ACCESS : IDLE;
      ACCESS: begin
        mem_addr = addr_q;
        mem_we   = we_q && !sub_q;
        mem_wd   = wd_q;
        nxt      = sub_q ? RMW_WR : RESP;
      end
      RMW_WR: begin
        mem_addr = addr_q;
        mem_we   = 1'b1;
        mem_wd   = rmw_wd;
        nxt      = RESP;
      end
      default: nxt = IDLE;
    endcase
  end
  // latch the granted request, capture memory data, and register read results into RESP
  always_ff @(posedge clk)
    if (reset) begin
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      if (state == IDLE && (req0 || req1)) begin
        port_q <= gnt;
        we_q   <= gnt ? we1 : we0;
        size_q <= gnt ? size1 : size0;
        addr_q <= gnt ? addr1 : addr0;
        wd_q   <= gnt ? wd1 : wd0;
      end
      if (state == ACCESS) begin
        rd_buf <= mem_rd;
        if (!we_q && port_q) rdata1 <= rd_mask;
        if (!we_q && !port_q) rdata0 <= rd_mask;
      end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table-driven checks of arbitration, latency, RMW stores and reset
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  logic        clk = 0, reset = 1;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [1:0]  size0 = 0, size1 = 0;
  logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
  logic [31:0] rdata0, rdata1, mem_addr, mem_wd, mem_rd;
  logic        ack0, ack1, mem_we, busy;
  logic [7:0]  mem [256];
  logic [7:0]  ma;
  int          pass = 0, total = 0;

  typedef struct {
    bit          port;
    bit          we;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
    bit          drop;
  } vec_t;
  vec_t vecs[11];

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .size0(size0), .size1(size1), .addr0(addr0), .addr1(addr1),
    .wd0(wd0), .wd1(wd1), .rdata0(rdata0), .rdata1(rdata1),
    .ack0(ack0), .ack1(ack1), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
  );

  always #5 clk = ~clk;

  assign ma = mem_addr[7:0];
  assign mem_rd = {mem[ma + 8'd3], mem[ma + 8'd2], mem[ma + 8'd1], mem[ma]};
  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++) mem[8'(int'(ma) + i)] <= mem_wd[8*i +: 8];

  function automatic logic [31:0] rdw(input logic [7:0] a);
    return {mem[a + 8'd3], mem[a + 8'd2], mem[a + 8'd1], mem[a]};
  endfunction

  task automatic wrw(input logic [7:0] a, input logic [31:0] d);
    for (int i = 0; i < 4; i++) mem[8'(int'(a) + i)] = d[8*i +: 8];
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else pass++;
  endtask

  task automatic clear_req();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
  endtask

  task automatic txn(input vec_t v);
    int   cyc = 0, wecnt = 0;
    logic got = 0, other = 0;
    @(negedge clk);
    if (v.port) begin req1 = 1; we1 = v.we; size1 = v.size; addr1 = v.addr; wd1 = v.wd; end
    else begin req0 = 1; we0 = v.we; size0 = v.size; addr0 = v.addr; wd0 = v.wd; end
    while (!got && cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (v.drop && cyc == 1) clear_req();
      if (mem_we) begin
        wecnt++;
        chk("we_addr", mem_addr, v.addr);
      end
      if (v.port ? ack1 : ack0) got = 1;
      if (v.port ? ack0 : ack1) other = 1;
    end
    clear_req();
    chk("latency", got ? cyc : 99, v.lat);
    chk("other_ack", {31'd0, other}, 0);
    chk("we_pulses", wecnt, v.we ? 1 : 0);
    if (v.we) chk("mem_word", rdw(v.addr[7:0]), v.exp);
    else chk("rdata", v.port ? rdata1 : rdata0, v.exp);
  endtask

  initial begin
    int order[4];
    int n, cyc, cnt;
    logic both;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    wrw(8'h10, 32'hDEADBEEF);
    wrw(8'h30, 32'h01020304);
    wrw(8'h40, 32'h11223344);
    wrw(8'h44, 32'h55667788);
    vecs[0]  = '{1'b0, 1'b0, SZ_WORD, 32'h10, 32'h0,        32'hDEADBEEF, 2, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, SZ_WORD, 32'h20, 32'h12345678, 32'h12345678, 2, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0,        32'h12345678, 2, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, SZ_BYTE, 32'h20, 32'h777777AA, 32'h123456AA, 3, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, SZ_HALF, 32'h20, 32'h0,        32'h000056AA, 2, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, SZ_BYTE, 32'h20, 32'h0,        32'h000000AA, 2, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, SZ_HALF, 32'h22, 32'h5555BEEF, 32'h0000BEEF, 3, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, SZ_WORD, 32'h20, 32'h0,        32'hBEEF56AA, 2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b11,   32'h10, 32'h0,        32'hDEADBEEF, 2, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 2'b11,   32'h30, 32'hCAFEF00D, 32'hCAFEF00D, 2, 1'b0};
    vecs[10] = '{1'b0, 1'b0, SZ_WORD, 32'h30, 32'h0,        32'hCAFEF00D, 2, 1'b1};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_ack", {30'd0, ack1, ack0}, 0);
    chk("rst_rdata0", rdata0, 0);
    chk("rst_rdata1", rdata1, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wd", mem_wd, 0);
    reset = 0;

    // simultaneous requests held high: grant order and 3-cycle throughput
    n = 0; cyc = 0; both = 0;
    for (int i = 0; i < 4; i++) order[i] = 9;
    @(negedge clk);
    req0 = 1; req1 = 1; size0 = SZ_WORD; size1 = SZ_WORD; addr0 = 32'h10; addr1 = 32'h30;
    while (n < 4 && cyc < 40) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (ack0 && ack1) both = 1;
      if (ack0) begin chk("arb_rdata0", rdata0, 32'hDEADBEEF); order[n] = 0; n++; end
      else if (ack1) begin chk("arb_rdata1", rdata1, 32'h01020304); order[n] = 1; n++; end
    end
    clear_req();
    chk("arb_count", n, 4);
    chk("arb_both", {31'd0, both}, 0);
    chk("arb_span", cyc, 11);
    for (int i = 0; i < 4; i++)
`ifdef ARB_FIXED_PRI_EN
      chk("arb_order", order[i], 0);
`else
      chk("arb_order", order[i], i % 2);
`endif

    for (int i = 0; i < 11; i++) txn(vecs[i]);

    // reset during RMW_WR: the write in that cycle lands, then idle with no ack
    @(negedge clk);
    req1 = 1; we1 = 1; size1 = SZ_BYTE; addr1 = 32'h40; wd1 = 32'h000000BB;
    @(posedge clk);
    @(negedge clk);
    chk("rmw_access_we", {31'd0, mem_we}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rmw_wr_we", {31'd0, mem_we}, 1);
    chk("rmw_wr_wd", mem_wd, 32'h112233BB);
    reset = 1; clear_req();
    @(posedge clk);
    @(negedge clk);
    chk("rst_rmw_busy", {31'd0, busy}, 0);
    chk("rst_rmw_we", {31'd0, mem_we}, 0);
    chk("rst_rmw_ack", {30'd0, ack1, ack0}, 0);
    chk("rst_rmw_mem", rdw(8'h40), 32'h112233BB);
    reset = 0;
    cnt = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
      if (ack0 || ack1 || mem_we || busy) cnt++;
    end
    chk("post_rst_quiet", cnt, 0);

    // reset during ACCESS of a byte store: no RMW write ever issues
    @(negedge clk);
    req1 = 1; we1 = 1; size1 = SZ_BYTE; addr1 = 32'h44; wd1 = 32'h000000CC;
    @(posedge clk);
    @(negedge clk);
    reset = 1; clear_req();
    cnt = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 0;
    repeat (4) begin
      if (ack0 || ack1 || mem_we) cnt++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_access_quiet", cnt, 0);
    chk("rst_access_mem", rdw(8'h44), 32'h55667788);

    txn('{1'b0, 1'b0, SZ_WORD, 32'h40, 32'h0, 32'h112233BB, 2, 1'b0});

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
